// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: PC write-back, instruction-memory read port and decode handshake.
// Master modport is the fetch sequencer; slave modport is everything around it.
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              fetch_en;
    logic [ADDR_W-1:0] pc_in;
    logic              pWrite;
    logic [ADDR_W-1:0] pc_wdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_out;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;

    modport master (
        input  fetch_en, pc_in, mem_ack, mem_rdata, ir_ready, br_taken, br_target,
        output pWrite, pc_wdata, mem_req, mem_addr, ir_valid, ir_out, ir_pc
    );

    modport slave (
        output fetch_en, pc_in, mem_ack, mem_rdata, ir_ready, br_taken, br_target,
        input  pWrite, pc_wdata, mem_req, mem_addr, ir_valid, ir_out, ir_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads instruction memory, hands words to decode,
// and writes the sequential or redirected next PC back to the program counter.
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] pc_wdata_q, pc_wdata_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              ir_valid_q, ir_valid_d;
    logic [DATA_W-1:0] ir_out_q, ir_out_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_d    = state_q;
        pwrite_d   = 1'b0;
        pc_wdata_d = pc_wdata_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ir_valid_d = ir_valid_q;
        ir_out_d   = ir_out_q;
        ir_pc_d    = ir_pc_q;
        tgt_d      = tgt_q;

        // A redirect always updates the PC and kills any presented instruction.
        if (bus.br_taken) begin
            pwrite_d   = 1'b1;
            pc_wdata_d = bus.br_target;
            ir_valid_d = 1'b0;
            tgt_d      = bus.br_target;
        end

        unique case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (!bus.br_taken && bus.fetch_en) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.pc_in;
                end
            end

            FETCH: begin
                if (bus.br_taken) begin
                    if (bus.mem_ack) begin
                        mem_addr_d = bus.br_target;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (bus.mem_ack) begin
                    state_d    = HOLD;
                    mem_req_d  = 1'b0;
                    ir_out_d   = bus.mem_rdata;
                    ir_pc_d    = mem_addr_q;
                    ir_valid_d = 1'b1;
                    pwrite_d   = 1'b1;
                    pc_wdata_d = addr_inc(mem_addr_q);
                end
            end

            DRAIN: begin
                // The read in flight cannot be aborted; its data is thrown away.
                if (bus.mem_ack) begin
                    state_d    = FETCH;
                    mem_addr_d = bus.br_taken ? bus.br_target : tgt_q;
                end
            end

            HOLD: begin
                if (bus.br_taken) begin
                    state_d    = FETCH;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.br_target;
                end else if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    if (bus.fetch_en) begin
                        // PC is being rewritten this edge, so use the local copy.
                        state_d    = FETCH;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_inc(ir_pc_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pwrite_q   <= 1'b0;
            pc_wdata_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ir_valid_q <= 1'b0;
            ir_out_q   <= '0;
            ir_pc_q    <= '0;
            tgt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pwrite_q   <= pwrite_d;
            pc_wdata_q <= pc_wdata_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ir_valid_q <= ir_valid_d;
            ir_out_q   <= ir_out_d;
            ir_pc_q    <= ir_pc_d;
            tgt_q      <= tgt_d;
        end
    end

    assign bus.pWrite   = pwrite_q;
    assign bus.pc_wdata = pc_wdata_q;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.ir_out   = ir_out_q;
    assign bus.ir_pc    = ir_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, streaming, backpressure, redirects,
// address wrap and asynchronous reset in mid-transaction.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    instr_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    instr_fetch #(.ADDR_W(16), .DATA_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [15:0] addr,
                              input logic vld, input logic pw);
        check_vec({tag, ".mem_req"},  32'(bus.mem_req),  32'(req));
        check_vec({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(addr));
        check_vec({tag, ".ir_valid"}, 32'(bus.ir_valid), 32'(vld));
        check_vec({tag, ".pWrite"},   32'(bus.pWrite),   32'(pw));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fetch_en  = 1'b0;
        bus.pc_in     = 16'h0000;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        bus.ir_ready  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 16'h0000;

        // Reset values
        tick();
        tick();
        check_outs("rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        check_vec("rst.pc_wdata", 32'(bus.pc_wdata), 32'h0);
        check_vec("rst.ir_out",   32'(bus.ir_out),   32'h0);
        check_vec("rst.ir_pc",    32'(bus.ir_pc),    32'h0);

        // First fetch from 0000
        rst = 1'b0;
        bus.fetch_en = 1'b1;
        bus.pc_in    = 16'h0000;
        tick();
        check_outs("f0", 1'b1, 16'h0000, 1'b0, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hA5A5;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("f0ack", 1'b0, 16'h0000, 1'b1, 1'b1);
        check_vec("f0ack.ir_out",   32'(bus.ir_out),   32'hA5A5);
        check_vec("f0ack.ir_pc",    32'(bus.ir_pc),    32'h0000);
        check_vec("f0ack.pc_wdata", 32'(bus.pc_wdata), 32'h0001);
        tick();
        check_outs("f0hold", 1'b0, 16'h0000, 1'b1, 1'b0);

        // Stream with decode always ready
        bus.ir_ready = 1'b1;
        tick();
        check_outs("s1req", 1'b1, 16'h0001, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 16'h1000 + 16'(k);
            tick();
            bus.mem_ack = 1'b0;
            check_outs("sack", 1'b0, 16'(k), 1'b1, 1'b1);
            check_vec("sack.ir_out",   32'(bus.ir_out),   32'h1000 + 32'(k));
            check_vec("sack.ir_pc",    32'(bus.ir_pc),    32'(k));
            check_vec("sack.pc_wdata", 32'(bus.pc_wdata), 32'(k + 1));
            tick();
            check_outs("sreq", 1'b1, 16'(k + 1), 1'b0, 1'b0);
        end

        // Backpressure at address 0004
        bus.ir_ready  = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("bpack", 1'b0, 16'h0004, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_outs("bphold", 1'b0, 16'h0004, 1'b1, 1'b0);
            check_vec("bphold.ir_out", 32'(bus.ir_out), 32'hBEEF);
            check_vec("bphold.ir_pc",  32'(bus.ir_pc),  32'h0004);
        end
        bus.ir_ready = 1'b1;
        tick();
        check_outs("bprel", 1'b1, 16'h0005, 1'b0, 1'b0);

        // Redirect while the read at 0005 is still outstanding
        tick();
        tick();
        check_outs("rwait", 1'b1, 16'h0005, 1'b0, 1'b0);
        bus.br_taken  = 1'b1;
        bus.br_target = 16'h0040;
        tick();
        bus.br_taken = 1'b0;
        check_outs("rbr", 1'b1, 16'h0005, 1'b0, 1'b1);
        check_vec("rbr.pc_wdata", 32'(bus.pc_wdata), 32'h0040);
        tick();
        check_outs("rdrain", 1'b1, 16'h0005, 1'b0, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("rdrop", 1'b1, 16'h0040, 1'b0, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h1234;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("rtgt", 1'b0, 16'h0040, 1'b1, 1'b1);
        check_vec("rtgt.ir_out",   32'(bus.ir_out),   32'h1234);
        check_vec("rtgt.pc_wdata", 32'(bus.pc_wdata), 32'h0041);
        tick();
        check_outs("rnext", 1'b1, 16'h0041, 1'b0, 1'b0);

        // Redirect on the same edge as the ack
        bus.br_taken  = 1'b1;
        bus.br_target = 16'h0080;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h5555;
        tick();
        bus.br_taken = 1'b0;
        bus.mem_ack  = 1'b0;
        check_outs("rack", 1'b1, 16'h0080, 1'b0, 1'b1);
        check_vec("rack.pc_wdata", 32'(bus.pc_wdata), 32'h0080);

        // fetch_en dropped: complete the read, then idle after the handshake
        bus.fetch_en  = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h7777;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("stop", 1'b0, 16'h0080, 1'b1, 1'b1);
        check_vec("stop.ir_pc", 32'(bus.ir_pc), 32'h0080);
        tick();
        check_outs("idle", 1'b0, 16'h0080, 1'b0, 1'b0);

        // Address wrap from FFFF
        bus.fetch_en = 1'b1;
        bus.pc_in    = 16'hFFFF;
        tick();
        check_outs("wreq", 1'b1, 16'hFFFF, 1'b0, 1'b0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h0F0F;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("wack", 1'b0, 16'hFFFF, 1'b1, 1'b1);
        check_vec("wack.pc_wdata", 32'(bus.pc_wdata), 32'h0000);
        tick();
        check_outs("wnext", 1'b1, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset with a read outstanding; late ack is ignored
        rst = 1'b1;
        #1;
        check_outs("arst", 1'b0, 16'h0000, 1'b0, 1'b0);
        bus.fetch_en = 1'b0;
        tick();
        rst = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'h9999;
        tick();
        bus.mem_ack = 1'b0;
        check_outs("late", 1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        check_outs("late2", 1'b0, 16'h0000, 1'b0, 1'b0);
        check_vec("late2.ir_out", 32'(bus.ir_out), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch sequencer that sits on the other side of the program counter. It is the only block that reads the PC's `out` and the only block that drives the PC's `pWrite`/`temp_in`. It issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction to decode with a valid/ready handshake, and writes back the sequential or redirected next PC.

Parameters:
ADDR_W, 16, PC / instruction-memory word-address width
DATA_W, 16, instruction width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
fetch_en  in  1  1 = fetch continuously; 0 = finish current instruction, then idle
pc_in  in  ADDR_W  current PC (from PC `out`); sampled only when leaving IDLE
pWrite  out  1  one-cycle PC write strobe (to PC `pWrite`)
pc_wdata  out  ADDR_W  value to load into PC (to PC `temp_in`)
mem_req  out  1  instruction memory read request
mem_addr  out  ADDR_W  read word address, stable while mem_req=1
mem_ack  in  1  read complete; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  read data
ir_valid  out  1  instruction available to decode
ir_out  out  DATA_W  fetched instruction
ir_pc  out  ADDR_W  address ir_out was fetched from
ir_ready  in  1  decode accepts ir_out this cycle
br_taken  in  1  one-cycle redirect request from execute
br_target  in  ADDR_W  redirect address, valid with br_taken

Behaviour:
- Reset (async, immediate):
  - state=IDLE; the drop flag is cleared.
  - pWrite, mem_req and ir_valid are 0.
  - pc_wdata, mem_addr, ir_out and ir_pc are 0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - mem_req=0; mem_ack is ignored.
  - fetch_en=1 -> FETCH, with mem_addr<=pc_in.
- FETCH: mem_req=1, mem_addr held. On an edge with mem_ack=1:
  - ir_out<=mem_rdata, ir_pc<=mem_addr, ir_valid<=1.
  - pWrite<=1, pc_wdata<=mem_addr+1 (mod 2^ADDR_W; FFFF wraps to 0000).
  - mem_req<=0, next state HOLD.
  - Latency: ack edge -> ir_valid and pWrite high in the following cycle.
- HOLD:
  - ir_valid stays 1 and ir_out/ir_pc stay stable until ir_ready=1 is sampled.
  - On that edge: ir_valid<=0.
  - If fetch_en=1: -> FETCH with mem_addr<=ir_pc+1. The internal copy is used, not pc_in, because the PC is being updated on that same edge.
  - If fetch_en=0: -> IDLE.
- DRAIN:
  - mem_req=1 and mem_addr are held; the outstanding read is not abortable.
  - On mem_ack: data discarded, ir_valid unchanged (0), -> FETCH with mem_addr<=the latched redirect target.
- pWrite is high for exactly one cycle per accepted fetch or redirect, and is 0 otherwise.
- fetch_en=0 during FETCH/DRAIN: the transaction completes normally; the block idles after the HOLD handshake.
- Redirect (br_taken=1 sampled), any state; takes priority over sequential update:
  - pWrite<=1, pc_wdata<=br_target, ir_valid<=0. Target is latched internally.
  - IDLE: stays IDLE (PC is still updated).
  - HOLD: -> FETCH at br_target. If ir_ready=1 on the same edge, the handshake counts as done but redirect still governs the next state.
  - FETCH, mem_ack=0: -> DRAIN.
  - FETCH, mem_ack=1 same edge: data discarded, -> FETCH at br_target. mem_req may stay high back-to-back; each ack completes exactly one request.
  - DRAIN: the latched target is replaced by the newer br_target.
- Reset mid-transaction: mem_req drops immediately. A late mem_ack after reset release is ignored because the block is in IDLE.

Test Plan:
- Reset sequence: rst=1 -> all outputs 0. rst=0, fetch_en=1, pc_in=0000 -> mem_req=1, mem_addr=0000. Ack with rdata=A5A5 -> next cycle ir_valid=1, ir_out=A5A5, ir_pc=0000, pWrite=1 for one cycle, pc_wdata=0001.
- Stream: ir_ready tied 1, mem_ack one cycle after each req -> mem_addr sequence 0000,0001,0002,0003. One pWrite pulse per fetch.
- Backpressure: ir_ready=0 for 5 cycles -> ir_valid/ir_out stable and no new mem_req. ir_ready=1 -> next mem_addr=ir_pc+1.
- Redirect in FETCH: ack delayed 3 cycles, br_taken with br_target=0040 -> pWrite=1 with pc_wdata=0040 and the block enters DRAIN. Acked data is not presented. Next mem_addr=0040.
- Wrap: pc_in=FFFF fetched -> pc_wdata=0000, next mem_addr=0000.
- Async reset while mem_req=1 -> mem_req=0 immediately. Then ack pulsed after release with fetch_en=0 -> no ir_valid and no pWrite.
